// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU, host loader) for the single-port program/data memory.
// Optional MEM_ARB_STATS_EN adds saturating CPU-wait and host-grant counters.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          Rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  input  logic          host_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_wait,
  output logic [15:0]   stat_host_grants
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          grant_id_q, grant_id_d;     // 1 = host owns the current transaction
  logic          last_grant_q, last_grant_d; // 1 = host was granted most recently
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic cpu_elig, host_elig, grant_valid, pick_host;

  always_comb begin
    cpu_elig    = cpu_req & ~host_lock;
    host_elig   = host_req;
    grant_valid = (state_q == IDLE) && (cpu_elig || host_elig);
    // On contention the requester that did not win last time gets the port.
    pick_host   = host_elig && (!cpu_elig || !last_grant_q);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant_id_d   = pick_host;
          last_grant_d = pick_host;
          mem_we_d     = pick_host ? host_we    : cpu_we;
          mem_addr_d   = pick_host ? host_addr  : cpu_addr;
          mem_wdata_d  = pick_host ? host_wdata : cpu_wdata;
          cnt_d        = 3'd0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT_C) begin
          if (!mem_we_q) begin
            if (grant_id_q) host_rdata_d = mem_rdata;
            else            cpu_rdata_d  = mem_rdata;
          end
          // Write enable is only asserted for the duration of the access.
          mem_we_d = 1'b0;
          cnt_d    = 3'd0;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_en     = (state_q == ACCESS) && (cnt_q == 3'd0);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = (state_q == RESP) && !grant_id_q;
  assign host_ack   = (state_q == RESP) &&  grant_id_q;
  assign busy       = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [15:0] stat_cpu_wait_q, stat_cpu_wait_d;
  logic [15:0] stat_host_grants_q, stat_host_grants_d;
  logic        cpu_served;

  always_comb begin
    // The CPU counts as served from the cycle it is granted until its ack.
    cpu_served         = ((state_q != IDLE) && !grant_id_q) || (grant_valid && !pick_host);
    stat_cpu_wait_d    = sat_inc16(stat_cpu_wait_q, cpu_req && !cpu_served);
    stat_host_grants_d = sat_inc16(stat_host_grants_q, grant_valid && pick_host);
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_cpu_wait_q    <= 16'd0;
      stat_host_grants_q <= 16'd0;
    end else begin
      stat_cpu_wait_q    <= stat_cpu_wait_d;
      stat_host_grants_q <= stat_host_grants_d;
    end
  end

  assign stat_cpu_wait    = stat_cpu_wait_q;
  assign stat_host_grants = stat_host_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LAT=1 instance with a memory model
// and a MEM_LAT=3 instance for latency checks.
module tb_mem_port_arbiter;
  localparam int AW = 8, DW = 16, LAT = 1, LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, host_ack, mem_en, mem_we, busy;

  logic cpu_req3;
  logic [AW-1:0] cpu_addr3, mem_addr3;
  logic [DW-1:0] cpu_rdata3, host_rdata3, mem_wdata3, mem_rdata3;
  logic cpu_ack3, host_ack3, mem_en3, mem_we3, busy3;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cpu_wait, stat_host_grants, stat_cpu_wait3, stat_host_grants3;
  logic [15:0] base_w, base_h;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .Rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_lock(host_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_wait(stat_cpu_wait), .stat_host_grants(stat_host_grants)
`endif
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT3)) u_dut3 (
    .clk(clk), .Rst_n(rst_n),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(16'h0000),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
    .host_req(1'b0), .host_we(1'b0), .host_addr(8'h00), .host_wdata(16'h0000),
    .host_rdata(host_rdata3), .host_ack(host_ack3), .host_lock(1'b0),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_wait(stat_cpu_wait3), .stat_host_grants(stat_host_grants3)
`endif
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: read data valid exactly LAT cycles after the mem_en cycle.
  function automatic logic [15:0] mem_init(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hA5C3;
      8'h30:   return 16'h0F0F;
      default: return {a, ~a};
    endcase
  endfunction

  logic [15:0] mem_w [256];
  bit          written [256];
  logic [15:0] rd_dat [8];
  bit   [7:0]  rd_vld = 8'h00;
  bit   [2:0]  v3 = 3'b000;

  always @(posedge clk) begin
    rd_vld    <= {rd_vld[6:0], mem_en & ~mem_we};
    rd_dat[0] <= written[mem_addr] ? mem_w[mem_addr] : mem_init(mem_addr);
    for (int i = 1; i < 8; i++) rd_dat[i] <= rd_dat[i-1];
    if (mem_en & mem_we) begin
      written[mem_addr] <= 1'b1;
      mem_w[mem_addr]   <= mem_wdata;
    end
    v3 <= {v3[1:0], mem_en3 & ~mem_we3};
  end
  assign mem_rdata  = rd_vld[LAT-1] ? rd_dat[LAT-1] : 16'hDEAD;
  assign mem_rdata3 = v3[LAT3-1] ? 16'h3C3C : 16'h5555;

  // Scoreboard: expected completions in order.
  typedef struct packed {logic host; logic rd; logic [15:0] data;} exp_t;
  exp_t exp_q[$];

  task automatic push(input logic host, input logic rd, input logic [15:0] data);
    exp_t e;
    e.host = host; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack | host_ack) begin
      chk_eq("ack_excl", cpu_ack & host_ack, 0);
      chk_eq("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_eq("ack_who", host_ack, e.host);
        if (e.rd) chk_eq(e.host ? "host_rdata" : "cpu_rdata", e.host ? host_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic wait_ack(output int c);
    bit got;
    got = 0; c = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack | host_ack) begin got = 1; c = cyc; end
    end
    chk_eq("ack_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c, nacks;
    int ca [4];
    rst_n = 0; host_lock = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    cpu_req3 = 0; cpu_addr3 = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk_eq("rst_ack", {cpu_ack, host_ack, cpu_ack3, host_ack3}, 0);
    chk_eq("rst_rdata", {cpu_rdata, host_rdata}, 0);
    chk_eq("rst_busy", {busy, busy3}, 0);
`ifdef MEM_ARB_STATS_EN
    chk_eq("rst_stats", {stat_cpu_wait, stat_host_grants}, 0);
`endif
    rst_n = 1;
    @(negedge clk);

    // Reset asserted during a CPU read aborts it.
    cpu_req = 1; cpu_addr = 8'h10; cpu_we = 0;
    @(negedge clk);
    chk_eq("abort_men_pre", mem_en, 1);
    rst_n = 0; cpu_req = 0;
    #1;
    chk_eq("abort_men", mem_en, 0);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_rdata", cpu_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    nacks = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack | host_ack) nacks++;
    end
    chk_eq("abort_noack", nacks, 0);

    // Contention: CPU wins first after reset, then strict alternation.
    cpu_req = 1; cpu_addr = 8'h40; host_req = 1; host_addr = 8'h30; host_we = 0;
    t0 = cyc;
    push(0, 1, 16'h40BF); push(1, 1, 16'h0F0F); push(0, 1, 16'h40BF); push(1, 1, 16'h0F0F);
    for (int k = 0; k < 4; k++) wait_ack(ca[k]);
    cpu_req = 0; host_req = 0;
    chk_eq("rr_first_lat", ca[0] - t0, LAT + 2);
    for (int k = 1; k < 4; k++) chk_eq("rr_spacing", ca[k] - ca[k-1], LAT + 3);
    repeat (2) @(negedge clk);

    // Lone CPU read, cycle by cycle.
    cpu_req = 1; cpu_addr = 8'h10; cpu_we = 0;
    push(0, 1, 16'hA5C3);
    @(negedge clk);
    chk_eq("rd_men_t1", mem_en, 1);
    chk_eq("rd_addr_t1", mem_addr, 8'h10);
    chk_eq("rd_busy_t1", busy, 1);
    chk_eq("rd_we_t1", mem_we, 0);
    @(negedge clk);
    chk_eq("rd_men_t2", mem_en, 0);
    chk_eq("rd_ack_t2", cpu_ack, 0);
    @(negedge clk);
    chk_eq("rd_ack_t3", cpu_ack, 1);
    chk_eq("rd_data_t3", cpu_rdata, 16'hA5C3);
    cpu_req = 0;
    @(negedge clk);
    chk_eq("rd_ack_t4", cpu_ack, 0);
    chk_eq("rd_busy_t4", busy, 0);
    chk_eq("rd_hold_t4", cpu_rdata, 16'hA5C3);

    // Host write followed by CPU read of the same word.
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 16'h1234;
    push(1, 0, 16'h0000);
    @(negedge clk);
    chk_eq("wr_men_t1", mem_en, 1);
    chk_eq("wr_we_t1", mem_we, 1);
    chk_eq("wr_addr_t1", mem_addr, 8'h20);
    chk_eq("wr_data_t1", mem_wdata, 16'h1234);
    @(negedge clk);
    chk_eq("wr_we_t2", mem_we, 1);
    chk_eq("wr_men_t2", mem_en, 0);
    @(negedge clk);
    chk_eq("wr_ack_t3", host_ack, 1);
    chk_eq("wr_we_t3", mem_we, 0);
    chk_eq("wr_rdata_keep", host_rdata, 16'h0F0F);
    host_req = 0; host_we = 0;
    cpu_req = 1; cpu_addr = 8'h20; cpu_we = 0;
    push(0, 1, 16'h1234);
    @(negedge clk);
    chk_eq("rbw_we_idle", mem_we, 0);
    @(negedge clk);
    chk_eq("rbw_men", mem_en, 1);
    chk_eq("rbw_we", mem_we, 0);
    wait_ack(c);
    cpu_req = 0;
    @(negedge clk);

    // Host lock: three host transactions, then the CPU on release.
`ifdef MEM_ARB_STATS_EN
    base_w = stat_cpu_wait; base_h = stat_host_grants;
`endif
    host_lock = 1;
    cpu_req = 1; cpu_addr = 8'h10; host_req = 1; host_addr = 8'h30; host_we = 0;
    t0 = cyc;
    push(1, 1, 16'h0F0F); push(1, 1, 16'h0F0F); push(1, 1, 16'h0F0F); push(0, 1, 16'hA5C3);
    for (int k = 0; k < 3; k++) wait_ack(ca[k]);
    chk_eq("lock_third_ack", ca[2] - t0, 3 * (LAT + 3) - 1);
    host_req = 0; host_lock = 0;
    @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    chk_eq("stat_cpu_wait", stat_cpu_wait - base_w, 12);
    chk_eq("stat_host_grants", stat_host_grants - base_h, 3);
`endif
    @(negedge clk);
    chk_eq("unlock_men", mem_en, 1);
    chk_eq("unlock_addr", mem_addr, 8'h10);
    wait_ack(c);
    chk_eq("unlock_ack_cyc", c - t0, 15);
    cpu_req = 0;
    @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    chk_eq("stat_cpu_wait_hold", stat_cpu_wait - base_w, 12);
`endif

    // MEM_LAT=3 instance: single strobe, capture only at the last access cycle.
    cpu_req3 = 1; cpu_addr3 = 8'h55;
    @(negedge clk);
    chk_eq("l3_men_t1", mem_en3, 1);
    chk_eq("l3_addr_t1", mem_addr3, 8'h55);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk_eq("l3_men_off", mem_en3, 0);
      chk_eq("l3_rdata_early", cpu_rdata3, 0);
      chk_eq("l3_ack_early", cpu_ack3, 0);
    end
    @(negedge clk);
    chk_eq("l3_ack_t5", cpu_ack3, 1);
    chk_eq("l3_rdata_t5", cpu_rdata3, 16'h3C3C);
    cpu_req3 = 0;
    @(negedge clk);
    chk_eq("l3_ack_t6", cpu_ack3, 0);
    chk_eq("l3_busy_t6", busy3, 0);
    chk_eq("l3_host_side", {host_ack3, mem_we3, host_rdata3, mem_wdata3}, 0);
`ifdef MEM_ARB_STATS_EN
    chk_eq("l3_stats", {stat_cpu_wait3, stat_host_grants3}, 0);
`endif

    repeat (3) @(negedge clk);
    chk_eq("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified program/data memory of the multicycle RISC between two requesters: the CPU controller (instruction fetch and LDR/STR accesses) and the host loader/debug port.
- Fixed-latency memory, one transaction in flight at a time.
- Round-robin grant on contention; host can lock out the CPU during program load.
- Sits between the Controller/datapath memory buffers and the memory macro.

Parameters:
AW, 8, address width
DW, 16, data width (instruction/word width)
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal 1..7

Ports:
clk  in  1  system clock, rising edge
Rst_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse to CPU
host_req  in  1  host access request, held until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_rdata  out  DW  host read data, registered
host_ack  out  1  one-cycle completion pulse to host
host_lock  in  1  1=CPU requests are never granted
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  1 when the FSM is not in IDLE

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low.
- While Rst_n=0:
  - FSM=IDLE, cnt=0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, both acks, both rdata, busy.
  - last_grant=HOST, so the CPU wins the first contention.
- Reset asserted mid-transaction aborts it: no ack is issued and no rdata is updated.

FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible requesters: cpu_req&~host_lock, and host_req.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one that is not last_grant, then update last_grant.
  - On grant: latch the requester's we/addr/wdata into mem_we/mem_addr/mem_wdata, set grant_id, go to ACCESS with cnt=0.
- ACCESS:
  - mem_en=1 only while cnt==0; mem_addr/mem_we/mem_wdata held stable for the whole state.
  - cnt increments each cycle.
  - At cnt==MEM_LAT: mem_rdata is captured into the granted requester's rdata register on that edge, for reads only (writes leave rdata unchanged). Go to RESP.
- RESP:
  - Granted requester's ack=1 for exactly one cycle. Go to IDLE.

Latency:
- Request first seen in IDLE at cycle T → ack at T+2+MEM_LAT.
- MEM_LAT=1: ack at T+3. Throughput: one transaction per MEM_LAT+3 cycles.

Requester rules:
- Hold req/we/addr/wdata stable until ack.
- req still high in the cycle after ack is a new transaction.
- rdata holds its value until that requester's next completed read.

Other rules:
- Changes to host_lock are sampled only in IDLE. An in-flight CPU transaction always completes.
- Requests that drop before being granted are ignored; nothing is latched.
- Never more than one ack per cycle. The two acks are mutually exclusive.
- busy=1 in ACCESS and RESP.

Optional Feature:
MEM_ARB_STATS_EN
- Defined:
  - Adds output stat_cpu_wait [15:0]: counts cycles with cpu_req=1 and the FSM not serving the CPU (CPU not granted, or CPU waiting behind the host).
  - Saturates at 16'hFFFF; reset to 0 by Rst_n.
  - Adds output stat_host_grants [15:0]: saturating count of host grants.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset mid-ACCESS (Rst_n low for 1 cycle at T+1 of a CPU read) → mem_en=0, no cpu_ack, cpu_rdata=0, busy=0 immediately. First post-reset contention is granted to the CPU.
- CPU read alone, MEM_LAT=1, addr=8'h10, memory returns 16'hA5C3 → mem_en pulse at T+1 with mem_addr=8'h10, cpu_ack at T+3, cpu_rdata=16'hA5C3 from T+3.
- Host write addr=8'h20 data=16'h1234, then CPU read of 8'h20 → host_ack once; cpu_rdata=16'h1234; mem_we=1 only during the host ACCESS.
- cpu_req and host_req held high continuously for 4 transactions → grant order CPU, HOST, CPU, HOST; acks never overlap; spacing is MEM_LAT+3 cycles.
- host_lock=1 with both requesting for 3 transactions → only host_ack pulses. Release host_lock → CPU granted in the next IDLE. With MEM_ARB_STATS_EN, stat_cpu_wait equals the counted CPU wait cycles.
- MEM_LAT=3, CPU read → mem_en high exactly 1 cycle, ack at T+5, rdata captured at cnt==3 only.
